// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, requester IDs and default widths.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker: combinational winner, registered last-granted requester.
module mem_port_arbiter_rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    i_req_if,
    input  logic    i_req_mem,
    input  logic    i_enable,
    input  logic    i_accept,
    output logic    o_gnt_if,
    output logic    o_gnt_mem,
    output req_id_e o_winner
);

    req_id_e r_rr_last;
    req_id_e w_winner;

    // Winner selection; a tie goes to whoever was not granted last
    always_comb begin
        w_winner = REQ_IF;
        if (i_req_if && i_req_mem) begin
            w_winner = (r_rr_last == REQ_IF) ? REQ_MEM : REQ_IF;
        end else if (i_req_mem) begin
            w_winner = REQ_MEM;
        end else begin
            w_winner = REQ_IF;
        end
    end

    assign o_gnt_if  = i_enable & i_req_if  & (w_winner == REQ_IF);
    assign o_gnt_mem = i_enable & i_req_mem & (w_winner == REQ_MEM);
    assign o_winner  = w_winner;

    // Remember the last accepted requester
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_last <= REQ_IF;
        end else if (i_accept) begin
            r_rr_last <= w_winner;
        end else begin
            r_rr_last <= r_rr_last;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch (IF) and load/store (MEM),
// one outstanding transaction at a time, with per-requester grant counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [STRB_W-1:0] mem_strb,
    output logic              mem_resp_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_strb,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [CNT_W-1:0]  if_grant_cnt,
    output logic [CNT_W-1:0]  mem_grant_cnt
);

    arb_state_e r_state;
    arb_state_e w_next_state;
    req_id_e    r_owner;
    req_id_e    w_winner;
    logic       w_idle;
    logic       w_accept;
    logic       w_resp_capture;

    assign w_idle         = (r_state == ARB_IDLE);
    assign w_accept       = (if_req_valid & if_req_ready) | (mem_req_valid & mem_req_ready);
    assign w_resp_capture = (r_state == ARB_WAIT) & bus_resp_valid;

    mem_port_arbiter_rr_arbiter2 u_rr (
        .clock     (clock),
        .reset     (reset),
        .i_req_if  (if_req_valid),
        .i_req_mem (mem_req_valid),
        .i_enable  (w_idle),
        .i_accept  (w_accept),
        .o_gnt_if  (if_req_ready),
        .o_gnt_mem (mem_req_ready),
        .o_winner  (w_winner)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; responses outside WAIT are never legal and are dropped
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: w_next_state = w_accept       ? ARB_REQ  : ARB_IDLE;
            ARB_REQ:  w_next_state = bus_req_ready  ? ARB_WAIT : ARB_REQ;
            ARB_WAIT: w_next_state = bus_resp_valid ? ARB_RESP : ARB_WAIT;
            ARB_RESP: w_next_state = ARB_IDLE;
            default:  w_next_state = ARB_IDLE;
        endcase
    end

    // Downstream request registers, owner and grant counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= {ADDR_W{1'b0}};
            bus_wdata     <= {DATA_W{1'b0}};
            bus_strb      <= {STRB_W{1'b0}};
            r_owner       <= REQ_IF;
            if_grant_cnt  <= {CNT_W{1'b0}};
            mem_grant_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            bus_req_valid <= 1'b1;
            r_owner       <= w_winner;
            if (w_winner == REQ_MEM) begin
                bus_we        <= mem_wen;
                bus_addr      <= mem_addr;
                bus_wdata     <= mem_wdata;
                bus_strb      <= mem_strb;
                mem_grant_cnt <= mem_grant_cnt + CNT_W'(1);
            end else begin
                bus_we        <= 1'b0;
                bus_addr      <= if_addr;
                bus_wdata     <= {DATA_W{1'b0}};
                bus_strb      <= {STRB_W{1'b1}};
                if_grant_cnt  <= if_grant_cnt + CNT_W'(1);
            end
        end else if ((r_state == ARB_REQ) && bus_req_ready) begin
            bus_req_valid <= 1'b0;
        end else begin
            bus_req_valid <= bus_req_valid;
        end
    end

    // Response capture: one-cycle pulse to the owner, rdata held until its next response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_resp_valid  <= 1'b0;
            mem_resp_valid <= 1'b0;
            if_rdata       <= {DATA_W{1'b0}};
            mem_rdata      <= {DATA_W{1'b0}};
        end else begin
            if_resp_valid  <= w_resp_capture & (r_owner == REQ_IF);
            mem_resp_valid <= w_resp_capture & (r_owner == REQ_MEM);
            if (w_resp_capture && (r_owner == REQ_IF)) begin
                if_rdata <= bus_rdata;
            end else if (w_resp_capture && (r_owner == REQ_MEM)) begin
                mem_rdata <= bus_rdata;
            end else begin
                if_rdata <= if_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand sequences for stalls, reset and counter wrap.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_addr = 64'h0;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        mem_req_valid = 1'b0;
    logic        mem_req_ready;
    logic        mem_wen = 1'b0;
    logic [63:0] mem_addr = 64'h0;
    logic [63:0] mem_wdata = 64'h0;
    logic [7:0]  mem_strb = 8'h0;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_strb;
    logic        bus_resp_valid = 1'b0;
    logic [63:0] bus_rdata = 64'h0;
    logic [31:0] if_grant_cnt;
    logic [31:0] mem_grant_cnt;

    // Narrow-counter twin sharing all stimulus, used to observe counter wrap
    logic        w2_if_req_ready, w2_if_resp_valid, w2_mem_req_ready, w2_mem_resp_valid;
    logic        w2_bus_req_valid, w2_bus_we;
    logic [63:0] w2_if_rdata, w2_mem_rdata, w2_bus_addr, w2_bus_wdata;
    logic [7:0]  w2_bus_strb;
    logic [1:0]  w2_if_grant_cnt, w2_mem_grant_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] FETCH_DATA = 64'h0000_0013_0000_0013;

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strb(bus_strb),
        .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata),
        .if_grant_cnt(if_grant_cnt), .mem_grant_cnt(mem_grant_cnt)
    );

    mem_port_arbiter #(.CNT_W(2)) dut_w (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(w2_if_req_ready), .if_addr(if_addr),
        .if_resp_valid(w2_if_resp_valid), .if_rdata(w2_if_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(w2_mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_resp_valid(w2_mem_resp_valid), .mem_rdata(w2_mem_rdata),
        .bus_req_valid(w2_bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(w2_bus_we),
        .bus_addr(w2_bus_addr), .bus_wdata(w2_bus_wdata), .bus_strb(w2_bus_strb),
        .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata),
        .if_grant_cnt(w2_if_grant_cnt), .mem_grant_cnt(w2_mem_grant_cnt)
    );

    typedef struct {
        logic        iv, mv, brdy, brsp;
        logic        exp_ifr, exp_mr, exp_bv, exp_ifv, exp_mv;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Single IF fetch from an IDLE cycle; zero-wait downstream, response three cycles after accept
    task automatic fetch_if(input logic [63:0] addr, input logic [63:0] data, input logic [31:0] exp_cnt);
        if_req_valid = 1'b1; if_addr = addr; bus_req_ready = 1'b1; bus_resp_valid = 1'b0;
        #1 chk("fetch_ready", {63'h0, if_req_ready}, 64'h1);
        cyc();
        if_req_valid = 1'b0;
        #1 chk("fetch_bus_valid", {63'h0, bus_req_valid}, 64'h1);
        chk("fetch_bus_addr", bus_addr, addr);
        cyc();
        bus_resp_valid = 1'b1; bus_rdata = data;
        #1;
        cyc();
        bus_resp_valid = 1'b0;
        #1 chk("fetch_resp_valid", {63'h0, if_resp_valid}, 64'h1);
        chk("fetch_rdata", if_rdata, data);
        chk("fetch_cnt", {32'h0, if_grant_cnt}, {32'h0, exp_cnt});
        cyc();
        #1 chk("fetch_resp_pulse", {63'h0, if_resp_valid}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //              iv    mv    brdy  brsp  ifr   mr    bv    ifv   mv    addr
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_1000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0000};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_1000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_bus_valid", {63'h0, bus_req_valid}, 64'h0);
        chk("rst_bus_strb", {56'h0, bus_strb}, 64'h0);
        chk("rst_if_cnt", {32'h0, if_grant_cnt}, 64'h0);
        chk("rst_mem_rdata", mem_rdata, 64'h0);
        reset = 1'b0;

        // Single fetch, then both requesters held valid: MEM, IF, MEM in turn
        if_addr = 64'h8000_0000; mem_addr = 64'h8000_1000; mem_wen = 1'b0;
        mem_strb = 8'hFF; bus_rdata = FETCH_DATA;
        for (int i = 0; i < 16; i++) begin
            if_req_valid = tbl[i].iv; mem_req_valid = tbl[i].mv;
            bus_req_ready = tbl[i].brdy; bus_resp_valid = tbl[i].brsp;
            #1;
            chk($sformatf("v%0d_if_ready", i), {63'h0, if_req_ready}, {63'h0, tbl[i].exp_ifr});
            chk($sformatf("v%0d_mem_ready", i), {63'h0, mem_req_ready}, {63'h0, tbl[i].exp_mr});
            chk($sformatf("v%0d_bus_valid", i), {63'h0, bus_req_valid}, {63'h0, tbl[i].exp_bv});
            chk($sformatf("v%0d_if_resp", i), {63'h0, if_resp_valid}, {63'h0, tbl[i].exp_ifv});
            chk($sformatf("v%0d_mem_resp", i), {63'h0, mem_resp_valid}, {63'h0, tbl[i].exp_mv});
            if (tbl[i].exp_bv) begin
                chk($sformatf("v%0d_bus_addr", i), bus_addr, tbl[i].exp_addr);
                chk($sformatf("v%0d_bus_we", i), {63'h0, bus_we}, 64'h0);
                chk($sformatf("v%0d_bus_strb", i), {56'h0, bus_strb}, 64'hFF);
            end
            if (tbl[i].exp_ifv) chk($sformatf("v%0d_if_rdata", i), if_rdata, FETCH_DATA);
            if (tbl[i].exp_mv) chk($sformatf("v%0d_mem_rdata", i), mem_rdata, FETCH_DATA);
            cyc();
        end
        chk("tbl_if_cnt", {32'h0, if_grant_cnt}, 64'd2);
        chk("tbl_mem_cnt", {32'h0, mem_grant_cnt}, 64'd2);

        // Store with downstream ready held low for five REQ cycles
        if_req_valid = 1'b0; mem_req_valid = 1'b1; mem_wen = 1'b1; mem_addr = 64'h8000_1008;
        mem_wdata = 64'hDEAD_BEEF; mem_strb = 8'h0F; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        #1 chk("st_ready", {63'h0, mem_req_ready}, 64'h1);
        cyc();
        mem_req_valid = 1'b0; mem_wen = 1'b0; mem_addr = 64'h0; mem_wdata = 64'h0; mem_strb = 8'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("st%0d_valid", k), {63'h0, bus_req_valid}, 64'h1);
            chk($sformatf("st%0d_addr", k), bus_addr, 64'h8000_1008);
            chk($sformatf("st%0d_wdata", k), bus_wdata, 64'hDEAD_BEEF);
            chk($sformatf("st%0d_strb", k), {56'h0, bus_strb}, 64'h0F);
            chk($sformatf("st%0d_we", k), {63'h0, bus_we}, 64'h1);
            cyc();
        end
        bus_req_ready = 1'b1;
        #1 chk("st_hs_valid", {63'h0, bus_req_valid}, 64'h1);
        cyc();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 64'h1234;
        #1 chk("st_wait_valid", {63'h0, bus_req_valid}, 64'h0);
        cyc();
        bus_resp_valid = 1'b0;
        #1 chk("st_mem_resp", {63'h0, mem_resp_valid}, 64'h1);
        chk("st_if_resp", {63'h0, if_resp_valid}, 64'h0);
        chk("st_if_rdata_hold", if_rdata, FETCH_DATA);
        cyc();
        #1 chk("st_mem_resp_pulse", {63'h0, mem_resp_valid}, 64'h0);
        chk("st_mem_cnt", {32'h0, mem_grant_cnt}, 64'd3);

        // Response delayed ten cycles while IF stays valid
        if_req_valid = 1'b1; if_addr = 64'h8000_0040; bus_req_ready = 1'b1;
        #1 chk("dl_accept", {63'h0, if_req_ready}, 64'h1);
        cyc();
        #1 chk("dl_req", {63'h0, bus_req_valid}, 64'h1);
        cyc();
        bus_req_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("dl%0d_ready", k), {63'h0, if_req_ready}, 64'h0);
            chk($sformatf("dl%0d_bus_valid", k), {63'h0, bus_req_valid}, 64'h0);
            cyc();
        end
        bus_resp_valid = 1'b1; bus_rdata = 64'hAAAA;
        #1;
        cyc();
        bus_resp_valid = 1'b0;
        #1 chk("dl_resp", {63'h0, if_resp_valid}, 64'h1);
        chk("dl_resp_ready", {63'h0, if_req_ready}, 64'h0);
        chk("dl_rdata", if_rdata, 64'hAAAA);
        cyc();
        #1 chk("dl_idle_ready", {63'h0, if_req_ready}, 64'h1);

        // Reset during WAIT, then a late response
        bus_req_ready = 1'b1;
        cyc();
        if_req_valid = 1'b0;
        #1;
        cyc();
        reset = 1'b1;
        #1;
        chk("ar_bus_valid", {63'h0, bus_req_valid}, 64'h0);
        chk("ar_bus_addr", bus_addr, 64'h0);
        chk("ar_if_cnt", {32'h0, if_grant_cnt}, 64'h0);
        chk("ar_mem_cnt", {32'h0, mem_grant_cnt}, 64'h0);
        chk("ar_if_rdata", if_rdata, 64'h0);
        cyc();
        reset = 1'b0; bus_resp_valid = 1'b1;
        #1;
        cyc();
        bus_resp_valid = 1'b0;
        #1;
        chk("ar_no_if_resp", {63'h0, if_resp_valid}, 64'h0);
        chk("ar_no_mem_resp", {63'h0, mem_resp_valid}, 64'h0);

        // Normal service after reset, and the narrow counter wrapping to zero
        fetch_if(64'h8000_0100, 64'h11, 32'd1);
        fetch_if(64'h8000_0108, 64'h22, 32'd2);
        fetch_if(64'h8000_0110, 64'h33, 32'd3);
        chk("wrap_pre", {62'h0, w2_if_grant_cnt}, 64'd3);
        fetch_if(64'h8000_0118, 64'h44, 32'd4);
        chk("wrap_cnt", {62'h0, w2_if_grant_cnt}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory port between two requesters: instruction fetch (IF) and data load/store (MEM).
- Replaces the dual-read-port memory assumption in the core top. Sits between the if/mem stages and the memory/bus adapter.
- One outstanding transaction at a time.
- Round-robin grant when both requesters are pending.
- Per-requester grant counters for perf dump.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; STRB_W = DATA_W/8.
- CNT_W, 32, width of each perf grant counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_resp_valid  out  1  one-cycle pulse, fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- mem_req_valid  in  1  data request.
- mem_req_ready  out  1  data request accepted.
- mem_wen  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_strb  in  STRB_W  store byte enables.
- mem_resp_valid  out  1  one-cycle pulse, load data valid or store done.
- mem_rdata  out  DATA_W  load data.
- bus_req_valid  out  1  downstream request.
- bus_req_ready  in  1  downstream accepts.
- bus_we  out  1  downstream write.
- bus_addr  out  ADDR_W  downstream address.
- bus_wdata  out  DATA_W  downstream write data.
- bus_strb  out  STRB_W  downstream byte enables.
- bus_resp_valid  in  1  downstream response.
- bus_rdata  in  DATA_W  downstream read data.
- if_grant_cnt  out  CNT_W  fetch grants since reset.
- mem_grant_cnt  out  CNT_W  data grants since reset.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, rr_last=IF (so MEM wins the first tie), owner=IF.
  - All registered outputs are 0: bus_*, resp_valid, rdata, counters.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready is combinational: asserted only for the winner, only in IDLE.
  - Winner when only one requester is valid: that requester.
  - Winner when both are valid: the one not equal to rr_last.
  - On accept (valid & ready):
    - Latch addr, we, wdata, strb into bus_* registers.
    - For IF: we=0, strb=all ones, wdata=0.
    - Set owner and rr_last to the winner; increment the winner's grant counter.
    - Go to REQ.
  - bus_resp_valid is ignored in IDLE.
- REQ: bus_req_valid=1 with fields held stable. When bus_req_ready is high, go to WAIT next cycle (bus_req_valid drops).
- WAIT:
  - bus_req_valid=0.
  - On bus_resp_valid, capture bus_rdata into the owner's rdata register and go to RESP.
  - A response arriving in the same cycle as the REQ handshake is not legal from downstream and is ignored.
- RESP:
  - Owner's resp_valid=1 for exactly one cycle, then IDLE.
  - No new request is accepted in RESP.
  - rdata holds until the next response to that requester.
  - For stores, resp_valid marks completion; mem_rdata is loaded with bus_rdata, value don't-care.
- Latency: with zero-wait downstream (ready in REQ, response the cycle after), request accept at cycle 0 gives resp_valid at cycle 3. Minimum request-to-request throughput is 4 cycles.
- Requester rule: req fields must stay stable while valid and not ready. Dropping valid before accept is allowed, and the arbiter re-evaluates each IDLE cycle.
- Counters wrap modulo 2^CNT_W without saturating.
- Reset mid-transaction: FSM returns to IDLE. Any late bus_resp_valid is ignored. No resp_valid pulse is produced for the aborted request.

Decomposition:
- Shared defines file: FSM state encodings (ARB_IDLE/REQ/WAIT/RESP, 2 bits), requester IDs (REQ_IF=0, REQ_MEM=1), default widths.
- One natural sub-module, rr_arbiter2: two-requester round-robin picker, combinational grant plus registered rr_last.
- Counters and FSM stay in the top module.

Test Plan:
- Reset then IF-only fetch of 0x8000_0000; downstream ready immediately, rdata=0x0000_0013_0000_0013 next cycle -> if_req_ready in cycle 0, bus_req_valid cycle 1 with strb=0xFF, we=0; if_resp_valid cycle 3 with that data; if_grant_cnt=1.
- IF and MEM valid simultaneously, then both held valid -> MEM granted first (rr_last=IF after reset), then IF, then MEM; grants alternate and counters track 2:1 after 3 grants.
- MEM store addr 0x8000_1008, wdata 0xDEAD_BEEF, strb 0x0F; downstream holds ready low 5 cycles -> bus fields stable for all 5 REQ cycles; mem_resp_valid single pulse after response; if_resp_valid stays 0.
- Downstream response delayed 10 cycles while IF is valid throughout -> if_req_ready stays 0 until IDLE; no second bus_req_valid while WAIT is outstanding.
- Assert reset during WAIT, then bus_resp_valid the next cycle -> all outputs 0 immediately, no resp_valid pulse, counters 0, next request served normally.
- Preload if_grant_cnt to 0xFFFF_FFFF via 2^32 grants (forced) -> next IF grant wraps it to 0.
